// File: rtl/alu_pkg.sv
// Opcode and FSM state definitions shared by the ALU/MDU block.
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_NOR   = 4'b1100;
   localparam logic [3:0] ALU_SLTU  = 4'b1000;
   localparam logic [3:0] ALU_MULT  = 4'b1001;
   localparam logic [3:0] ALU_MULTU = 4'b1010;
   localparam logic [3:0] ALU_DIV   = 4'b1011;
   localparam logic [3:0] ALU_DIVU  = 4'b1101;
   localparam logic [3:0] ALU_MFHI  = 4'b1110;
   localparam logic [3:0] ALU_MFLO  = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring step per
// cycle on operand magnitudes, with sign fix-up applied to the final step.
module alu_mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_is_div,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_step,
   output logic             o_last,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_mc;
   logic [CW-1:0]      r_cnt;
   logic               r_div;
   logic               r_neg_q;
   logic               r_neg_r;

   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_msum;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_nx_hi;
   logic [WIDTH-1:0]   w_nx_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_f;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                            input logic s);
      return (s && x[WIDTH-1]) ? -x : x;
   endfunction

   assign w_mag_a = mag(i_a, i_signed);
   assign w_mag_b = mag(i_b, i_signed);

   assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : '0);
   assign w_shift = {r_hi, r_lo[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_mc};

   always_comb begin
      w_nx_hi = '0;
      w_nx_lo = '0;
      if (r_div) begin
         // No borrow means the shifted remainder covers the divisor
         w_nx_hi = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
         w_nx_lo = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
      end else begin
         w_nx_hi = w_msum[WIDTH:1];
         w_nx_lo = {w_msum[0], r_lo[WIDTH-1:1]};
      end
   end

   assign w_prod   = {w_nx_hi, w_nx_lo};
   assign w_prod_f = r_neg_q ? -w_prod : w_prod;

   assign o_last = (r_cnt == '0);
   assign o_hi   = r_div ? (r_neg_r ? -w_nx_hi : w_nx_hi)
                         : w_prod_f[2*WIDTH-1:WIDTH];
   assign o_lo   = r_div ? (r_neg_q ? -w_nx_lo : w_nx_lo)
                         : w_prod_f[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi    <= '0;
         r_lo    <= '0;
         r_mc    <= '0;
         r_cnt   <= '0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (i_start) begin
         r_hi    <= '0;
         r_lo    <= i_is_div ? w_mag_a : w_mag_b;
         r_mc    <= i_is_div ? w_mag_b : w_mag_a;
         r_cnt   <= CW'(WIDTH - 1);
         r_div   <= i_is_div;
         r_neg_q <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
         r_neg_r <= i_signed & i_a[WIDTH-1];
      end else if (i_step) begin
         r_hi  <= w_nx_hi;
         r_lo  <= w_nx_lo;
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with single-cycle ops plus iterative MUL/DIV and HI/LO
// registers; valid/ready handshake stalls the pipeline while busy.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t           r_state;
   logic             r_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_dbz;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_accept;
   logic             w_is_mul;
   logic             w_is_div;
   logic             w_signed;
   logic             w_start;
   logic             w_step;
   logic [WIDTH-1:0] w_idle_res;
   logic             w_it_last;
   logic [WIDTH-1:0] w_it_hi;
   logic [WIDTH-1:0] w_it_lo;

   assign w_accept = in_valid & r_ready;
   assign w_is_mul = (alu_control == ALU_MULT) | (alu_control == ALU_MULTU);
   assign w_is_div = (alu_control == ALU_DIV) | (alu_control == ALU_DIVU);
   assign w_signed = (alu_control == ALU_MULT) | (alu_control == ALU_DIV);
   assign w_start  = w_accept & (w_is_mul | (w_is_div & (|input2)));
   assign w_step   = (r_state == S_MUL) | (r_state == S_DIV);

   always_comb begin
      w_idle_res = '0;
      case (alu_control)
         ALU_AND:  w_idle_res = input1 & input2;
         ALU_OR:   w_idle_res = input1 | input2;
         ALU_ADD:  w_idle_res = input1 + input2;
         ALU_SUB:  w_idle_res = input1 - input2;
         ALU_NOR:  w_idle_res = ~(input1 | input2);
         ALU_SLT:  w_idle_res = {{(WIDTH-1){1'b0}},
                                 $signed(input1) < $signed(input2)};
         ALU_SLTU: w_idle_res = {{(WIDTH-1){1'b0}}, input1 < input2};
         ALU_MFHI: w_idle_res = r_hi;
         ALU_MFLO: w_idle_res = r_lo;
         // Only reached on the divide-by-zero path
         ALU_DIV,
         ALU_DIVU: w_idle_res = '1;
         default:  w_idle_res = '0;
      endcase
   end

   alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_start),
      .i_is_div (w_is_div),
      .i_signed (w_signed),
      .i_a      (input1),
      .i_b      (input2),
      .i_step   (w_step),
      .o_last   (w_it_last),
      .o_hi     (w_it_hi),
      .o_lo     (w_it_lo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b1;
         r_dbz       <= 1'b0;
         r_hi        <= '0;
         r_lo        <= '0;
      end else begin
         r_out_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ready <= 1'b0;
                  if (w_start) begin
                     r_state <= w_is_mul ? S_MUL : S_DIV;
                  end else begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                     r_result    <= w_idle_res;
                     r_zero      <= (w_idle_res == '0);
                     r_dbz       <= w_is_div;
                     if (w_is_div) begin
                        r_hi <= input1;
                        r_lo <= '1;
                     end
                  end
               end
            end
            S_MUL, S_DIV: begin
               if (w_it_last) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_it_lo;
                  r_zero      <= (w_it_lo == '0);
                  r_dbz       <= 1'b0;
                  r_hi        <= w_it_hi;
                  r_lo        <= w_it_lo;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready    = r_ready;
   assign out_valid   = r_out_valid;
   assign result      = r_result;
   assign zero        = r_zero;
   assign div_by_zero = r_dbz;
   assign hi          = r_hi;
   assign lo          = r_lo;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu at WIDTH=32 and WIDTH=8.
module tb_alu_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic        v, rdy, ov, zr, dbz;
   logic [3:0]  op;
   logic [31:0] a, b, res, hi, lo;
   logic        v8, rdy8, ov8, zr8, dbz8;
   logic [3:0]  op8;
   logic [7:0]  a8, b8, res8, hi8, lo8;

   int n_chk = 0;
   int n_fail = 0;
   int lat;
   logic seen;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(v), .in_ready(rdy),
      .alu_control(op), .input1(a), .input2(b), .out_valid(ov),
      .result(res), .zero(zr), .div_by_zero(dbz), .hi(hi), .lo(lo)
   );

   alu_mdu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
      .alu_control(op8), .input1(a8), .input2(b8), .out_valid(ov8),
      .result(res8), .zero(zr8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input bit s8, input logic [3:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        output int l);
      @(negedge clk);
      if (s8) begin
         v8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
      end else begin
         v = 1'b1; op = o; a = x; b = y;
      end
      @(posedge clk);
      #1;
      v = 1'b0;
      v8 = 1'b0;
      l = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!(s8 ? ov8 : ov) && l < 100);
   endtask

   initial begin
      rst = 1'b1;
      v = 1'b0; op = 4'h0; a = '0; b = '0;
      v8 = 1'b0; op8 = 4'h0; a8 = '0; b8 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", rdy, 1);
      chk("rst_ov", ov, 0);
      chk("rst_res", res, 0);
      chk("rst_zero", zr, 1);
      chk("rst_dbz", dbz, 0);
      chk("rst_hilo", {hi, lo}, 0);

      issue(0, 4'b0010, 32'h7FFFFFFF, 32'h1, lat);
      chk("add_lat", lat, 1);
      chk("add_res", res, 32'h80000000);
      chk("add_zero", zr, 0);

      issue(0, 4'b0110, 32'd5, 32'd5, lat);
      chk("sub_res", res, 0);
      chk("sub_zero", zr, 1);

      issue(0, 4'b0111, 32'hFFFFFFFF, 32'h1, lat);
      chk("slt_res", res, 1);
      issue(0, 4'b1000, 32'hFFFFFFFF, 32'h1, lat);
      chk("sltu_res", res, 0);

      issue(0, 4'b1100, 32'hF0F0_0000, 32'h0000_000F, lat);
      chk("nor_res", res, 32'h0F0F_FFF0);
      issue(0, 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, lat);
      chk("and_res", res, 32'h0F00_0F00);
      issue(0, 4'b0011, 32'h1234, 32'h5678, lat);
      chk("undef_res", res, 0);
      chk("undef_lat", lat, 1);

      issue(0, 4'b1001, 32'hFFFFFFFD, 32'd7, lat);
      chk("mult_lat", lat, 33);
      chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
      chk("mult_res", res, 32'hFFFFFFEB);

      issue(0, 4'b0010, 32'd2, 32'd3, lat);
      chk("add_mid_res", res, 5);
      chk("add_mid_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
      issue(0, 4'b1111, 32'h0, 32'h0, lat);
      chk("mflo_res", res, 32'hFFFFFFEB);

      issue(0, 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
      chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

      issue(0, 4'b1011, 32'hFFFFFFF9, 32'd2, lat);
      chk("div_lat", lat, 33);
      chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      issue(0, 4'b1011, 32'h80000000, 32'hFFFFFFFF, lat);
      chk("div_min_hilo", {hi, lo}, 64'h00000000_80000000);
      chk("div_min_dbz", dbz, 0);

      issue(0, 4'b1101, 32'd9, 32'd0, lat);
      chk("dz_lat", lat, 1);
      chk("dz_flag", dbz, 1);
      chk("dz_hilo", {hi, lo}, 64'h00000009_FFFFFFFF);
      chk("dz_res", res, 32'hFFFFFFFF);
      issue(0, 4'b1110, 32'h0, 32'h0, lat);
      chk("mfhi_res", res, 9);
      chk("mfhi_dbz", dbz, 0);
      issue(0, 4'b1111, 32'h0, 32'h0, lat);
      chk("mflo_ones", res, 32'hFFFFFFFF);

      // Hold in_valid with changing operands while MULTU is busy
      @(negedge clk);
      v = 1'b1; op = 4'b1010; a = 32'd3; b = 32'd5;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 10) chk("busy_ready", rdy, 0);
         op = 4'b0010; a = 32'(lat); b = 32'(lat * 3);
      end while (!ov && lat < 100);
      v = 1'b0;
      chk("hold_lat", lat, 33);
      chk("hold_hilo", {hi, lo}, 64'h0000_0000_0000_000F);

      issue(0, 4'b1101, 32'd100, 32'd7, lat);
      chk("divu_hilo", {hi, lo}, 64'h00000002_0000000E);

      issue(1, 4'b1010, 32'hFF, 32'hFF, lat);
      chk("w8_lat", lat, 9);
      chk("w8_hilo", {hi8, lo8}, 16'hFE01);
      issue(1, 4'b1011, 32'hF9, 32'h02, lat);
      chk("w8_div_hilo", {hi8, lo8}, 16'hFFFD);

      // Reset in the middle of a DIVU
      @(negedge clk);
      v = 1'b1; op = 4'b1101; a = 32'd100; b = 32'd7;
      @(posedge clk);
      #1 v = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_ov", ov, 0);
      chk("abort_hilo", {hi, lo}, 0);
      chk("abort_ready", rdy, 1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen = seen | ov;
      end
      chk("abort_no_ov", seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
